mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single MEMORY access port between two requesters: port 0 is CORE, port 1 is a secondary master such as a loader or DMA.
- Sits between the requesters and MEMORY in the SoC top.
- Round-robin arbitration, one access issued per cycle.
- Read data is routed back to the issuing requester one cycle after issue.

Parameters:
- WIDTH, 32, address and data width; matches `WIDTH.
- MAX_HOLD, 8, maximum consecutive grants under lock before a forced release; range 1..255.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0_i  in  1  port 0 access request.
- we0_i  in  1  port 0 write(1) / read(0).
- addr0_i  in  WIDTH  port 0 address.
- wdata0_i  in  WIDTH  port 0 write data.
- gnt0_o  out  1  port 0 access issued this cycle.
- rvalid0_o  out  1  port 0 read data valid.
- rdata0_o  out  WIDTH  port 0 read data.
- req1_i, we1_i, addr1_i, wdata1_i, gnt1_o, rvalid1_o, rdata1_o: same as port 0, for port 1.
- lock0_i, lock1_i  in  1 each  hold grant across consecutive accesses; present only with the optional feature.
- memread_o  out  1  read strobe to MEMORY.
- memwrite_o  out  1  write strobe to MEMORY.
- memaddr_o  out  WIDTH  address to MEMORY.
- memwdata_o  out  WIDTH  write data to MEMORY.
- memrdata_i  in  WIDTH  MEMORY read data, valid the cycle after memread_o.

Behaviour:
- Reset (rst low, async):
  - last_grant=1, so port 0 wins first contention.
  - rd_owner pending=0; hold_cnt=0; locked=0.
  - All outputs 0.
- Grant is combinational from req*_i and state:
  - Exactly one gnt*_o at most per cycle.
  - gnt only when the corresponding req is high.
- Arbitration, cycle by cycle:
  - Only req0 high: grant 0. Only req1 high: grant 1. Neither: no grant, memread_o=memwrite_o=0.
  - Both high: grant the port != last_grant (round-robin).
  - last_grant updates to the granted port on every granted cycle.
- Memory drive in a granted cycle:
  - memaddr_o/memwdata_o are muxed from the granted port.
  - memread_o = ~we, memwrite_o = we of the granted port.
  - With no grant, memaddr_o/memwdata_o hold 0.
- Read return:
  - A granted read registers rd_pend=1 and rd_owner=port.
  - Next cycle: rvalid<owner>_o=1 and rdata<owner>_o=memrdata_i; the other port's rvalid=0.
  - rdata*_o are 0 whenever the matching rvalid is 0.
  - Back-to-back reads are fully pipelined (one response per cycle). No stall, so no FIFO is needed.
- Writes produce no rvalid. A write granted the cycle after a read is legal: the read response and the write issue overlap.
- A requester must hold req/we/addr/wdata stable until its gnt is seen; deasserting req before grant cancels the request.
- Reset mid-read: pending response is discarded; rvalid never asserts after reset release for a pre-reset request.
- Simultaneous events: a new grant and a return of the previous read in the same cycle are independent and both occur.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- Enabled:
  - lock*_i ports exist.
  - When the granted port has lock high, locked=1 and the arbiter keeps granting that port on subsequent cycles while its req stays high, ignoring round-robin.
  - hold_cnt increments per locked grant, up to MAX_HOLD.
  - If hold_cnt reaches MAX_HOLD and the other port is requesting, the other port is granted; then locked=0 and hold_cnt=0.
  - Lock also clears when the locking port drops req or lock.
- Disabled:
  - lock ports absent.
  - Pure round-robin; hold_cnt and locked logic not synthesized.

Test Plan:
- Reset release, both req0/req1 high with reads to 0x10/0x20:
  - gnt0 at cycle 1, gnt1 at cycle 2, alternating thereafter.
  - rvalid0 with data@0x10 at cycle 2, rvalid1 with data@0x20 at cycle 3.
- Only req1 writing 0xDEADBEEF to 0x40 for 3 cycles:
  - gnt1 every cycle, memwrite_o=1, memaddr_o=0x40, no rvalid.
  - A later port-0 read of 0x40 returns 0xDEADBEEF.
- Read (port 0, 0x8) then write (port 1) in consecutive cycles: rvalid0 and memwrite_o both high in cycle 2; rdata1_o=0.
- rst pulled low the cycle after a granted read:
  - All outputs 0 immediately (async).
  - After release, no rvalid appears; first contention grants port 0.
- MEM_ARB_LOCK_EN, MAX_HOLD=4, port 0 locked, req1 high throughout:
  - gnt0 for 4 consecutive cycles, then gnt1.
  - Without the macro: strict alternation.
- No requests for 10 cycles: memread_o=memwrite_o=0, memaddr_o=0, no gnt, no rvalid.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and MEMORY.
// Lock inputs exist only when MEM_ARB_LOCK_EN is defined.
interface mem_port_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_i;
    logic             we0_i;
    logic [WIDTH-1:0] addr0_i;
    logic [WIDTH-1:0] wdata0_i;
    logic             gnt0_o;
    logic             rvalid0_o;
    logic [WIDTH-1:0] rdata0_o;

    logic             req1_i;
    logic             we1_i;
    logic [WIDTH-1:0] addr1_i;
    logic [WIDTH-1:0] wdata1_i;
    logic             gnt1_o;
    logic             rvalid1_o;
    logic [WIDTH-1:0] rdata1_o;

`ifdef MEM_ARB_LOCK_EN
    logic             lock0_i;
    logic             lock1_i;
`endif

    logic             memread_o;
    logic             memwrite_o;
    logic [WIDTH-1:0] memaddr_o;
    logic [WIDTH-1:0] memwdata_o;
    logic [WIDTH-1:0] memrdata_i;

    // Arbiter side
    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  lock0_i, lock1_i,
`endif
        input  req0_i, we0_i, addr0_i, wdata0_i,
        input  req1_i, we1_i, addr1_i, wdata1_i,
        input  memrdata_i,
        output gnt0_o, rvalid0_o, rdata0_o,
        output gnt1_o, rvalid1_o, rdata1_o,
        output memread_o, memwrite_o, memaddr_o, memwdata_o
    );

    // Requester / memory side
    modport master (
`ifdef MEM_ARB_LOCK_EN
        output lock0_i, lock1_i,
`endif
        output req0_i, we0_i, addr0_i, wdata0_i,
        output req1_i, we1_i, addr1_i, wdata1_i,
        output memrdata_i,
        input  gnt0_o, rvalid0_o, rdata0_o,
        input  gnt1_o, rvalid1_o, rdata1_o,
        input  memread_o, memwrite_o, memaddr_o, memwdata_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the single MEMORY port, one access per cycle,
// read data returned to the issuer one cycle later. MEM_ARB_LOCK_EN adds grant locking.
module mem_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    logic [1:0]       req_vec;
    logic [1:0]       we_vec;
    logic [WIDTH-1:0] addr_arr  [2];
    logic [WIDTH-1:0] wdata_arr [2];
    logic [1:0]       gnt_vec;
    logic [1:0]       rvalid_vec;
    logic [WIDTH-1:0] rdata_arr [2];

    logic last_grant_reg, last_grant_next;
    logic rd_pend_reg,    rd_pend_next;
    logic rd_owner_reg,   rd_owner_next;

    logic rr_port;
    logic gnt_valid;
    logic gnt_port;
    logic issue;

    assign req_vec      = {bus.req1_i, bus.req0_i};
    assign we_vec       = {bus.we1_i,  bus.we0_i};
    assign addr_arr[0]  = bus.addr0_i;
    assign addr_arr[1]  = bus.addr1_i;
    assign wdata_arr[0] = bus.wdata0_i;
    assign wdata_arr[1] = bus.wdata1_i;

    always_comb begin
        rr_port = 1'b0;
        case (req_vec)
            2'b01:   rr_port = 1'b0;
            2'b10:   rr_port = 1'b1;
            2'b11:   rr_port = ~last_grant_reg;
            default: rr_port = 1'b0;
        endcase
    end

`ifdef MEM_ARB_LOCK_EN
    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    logic [1:0] lock_vec;
    logic       locked_reg,     locked_next;
    logic       lock_owner_reg, lock_owner_next;
    logic [7:0] hold_cnt_reg,   hold_cnt_next;
    logic       lock_hold;
    logic       force_rel;

    assign lock_vec = {bus.lock1_i, bus.lock0_i};

    always_comb begin
        lock_hold       = locked_reg && req_vec[lock_owner_reg] && lock_vec[lock_owner_reg];
        // Once the hold budget is spent, a waiting peer takes the next slot.
        force_rel       = lock_hold && (hold_cnt_reg >= HOLD_MAX) && req_vec[~lock_owner_reg];
        gnt_valid       = |req_vec;
        gnt_port        = rr_port;
        locked_next     = 1'b0;
        lock_owner_next = lock_owner_reg;
        hold_cnt_next   = 8'd0;
        if (force_rel) begin
            gnt_port = ~lock_owner_reg;
        end else if (lock_hold) begin
            gnt_port = lock_owner_reg;
        end
        if (gnt_valid && !force_rel && lock_vec[gnt_port]) begin
            locked_next     = 1'b1;
            lock_owner_next = gnt_port;
            if (!lock_hold) begin
                hold_cnt_next = 8'd1;
            end else if (hold_cnt_reg < HOLD_MAX) begin
                hold_cnt_next = hold_cnt_reg + 8'd1;
            end else begin
                hold_cnt_next = hold_cnt_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked_reg     <= 1'b0;
            lock_owner_reg <= 1'b0;
            hold_cnt_reg   <= 8'd0;
        end else begin
            locked_reg     <= locked_next;
            lock_owner_reg <= lock_owner_next;
            hold_cnt_reg   <= hold_cnt_next;
        end
    end
`else
    always_comb begin
        gnt_valid = |req_vec;
        gnt_port  = rr_port;
    end
`endif

    // Outputs are forced low combinationally while reset is held.
    assign issue = rst && gnt_valid;

    assign bus.memread_o  = issue && !we_vec[gnt_port];
    assign bus.memwrite_o = issue &&  we_vec[gnt_port];
    assign bus.memaddr_o  = issue ? addr_arr[gnt_port]  : '0;
    assign bus.memwdata_o = issue ? wdata_arr[gnt_port] : '0;

    always_comb begin
        last_grant_next = last_grant_reg;
        rd_owner_next   = rd_owner_reg;
        rd_pend_next    = 1'b0;
        if (gnt_valid) begin
            last_grant_next = gnt_port;
            rd_owner_next   = gnt_port;
            rd_pend_next    = !we_vec[gnt_port];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_reg <= 1'b1;
            rd_pend_reg    <= 1'b0;
            rd_owner_reg   <= 1'b0;
        end else begin
            last_grant_reg <= last_grant_next;
            rd_pend_reg    <= rd_pend_next;
            rd_owner_reg   <= rd_owner_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign gnt_vec[gi]    = issue && (gnt_port == 1'(gi));
            assign rvalid_vec[gi] = rst && rd_pend_reg && (rd_owner_reg == 1'(gi));
            assign rdata_arr[gi]  = rvalid_vec[gi] ? bus.memrdata_i : '0;
        end
    endgenerate

    assign bus.gnt0_o    = gnt_vec[0];
    assign bus.gnt1_o    = gnt_vec[1];
    assign bus.rvalid0_o = rvalid_vec[0];
    assign bus.rvalid1_o = rvalid_vec[1];
    assign bus.rdata0_o  = rdata_arr[0];
    assign bus.rdata1_o  = rdata_arr[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all outputs
// checked every cycle against a queue-level model; honours MEM_ARB_LOCK_EN.
module tb_mem_port_arbiter;
    localparam int W  = 32;
    localparam int MH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.WIDTH(W)) bus ();

    mem_port_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // MEMORY: registered read, initial content 0x1000_0000 + index
    logic [31:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
    always @(posedge clk) begin
        if (bus.memwrite_o) mem[bus.memaddr_o[7:0]] <= bus.memwdata_o;
        if (bus.memread_o)  bus.memrdata_i <= mem[bus.memaddr_o[7:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got 0x%08h, expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    // Reference model: who owns the bus this cycle and what each read must return
    logic [31:0] model_mem [256];
    bit          m_last  = 1'b1;
    bit          m_pend  = 1'b0;
    bit          m_owner = 1'b0;
    logic [31:0] m_data  = '0;
`ifdef MEM_ARB_LOCK_EN
    bit          m_locked = 1'b0;
    bit          m_lowner = 1'b0;
    int          m_hold   = 0;
`endif
    initial for (int i = 0; i < 256; i++) model_mem[i] = 32'h1000_0000 + i;

    always @(negedge clk) begin : cmp
        bit [1:0]    rq;
        bit [1:0]    we;
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        bit          v, g, forced, cont;
        bit [1:0]    lk;
        rq = {bus.req1_i, bus.req0_i};
        we = {bus.we1_i, bus.we0_i};
        ad[0] = bus.addr0_i;  ad[1] = bus.addr1_i;
        wd[0] = bus.wdata0_i; wd[1] = bus.wdata1_i;
        lk = 2'b00;
`ifdef MEM_ARB_LOCK_EN
        lk = {bus.lock1_i, bus.lock0_i};
`endif
        if (!rst) begin
            chk("rst_gnt",    {bus.gnt1_o, bus.gnt0_o}, 0);
            chk("rst_rvalid", {bus.rvalid1_o, bus.rvalid0_o}, 0);
            chk("rst_rdata0", bus.rdata0_o, 0);
            chk("rst_rdata1", bus.rdata1_o, 0);
            chk("rst_mem",    {bus.memread_o, bus.memwrite_o}, 0);
            chk("rst_maddr",  bus.memaddr_o, 0);
            chk("rst_mwdata", bus.memwdata_o, 0);
            m_last = 1'b1; m_pend = 1'b0; m_owner = 1'b0;
`ifdef MEM_ARB_LOCK_EN
            m_locked = 1'b0; m_hold = 0;
`endif
        end else begin
            v = (rq != 2'b00);
            if (rq == 2'b01)      g = 1'b0;
            else if (rq == 2'b10) g = 1'b1;
            else                  g = ~m_last;
            forced = 1'b0;
            cont   = 1'b0;
`ifdef MEM_ARB_LOCK_EN
            cont = m_locked && rq[m_lowner] && lk[m_lowner];
            if (cont) begin
                if (m_hold >= MH && rq[!m_lowner]) begin
                    g = !m_lowner; forced = 1'b1;
                end else begin
                    g = m_lowner;
                end
            end
`endif
            chk("gnt0",    bus.gnt0_o, v && !g);
            chk("gnt1",    bus.gnt1_o, v && g);
            chk("memread", bus.memread_o, v && !we[g]);
            chk("memwrite",bus.memwrite_o, v && we[g]);
            chk("memaddr", bus.memaddr_o, v ? ad[g] : 32'h0);
            chk("memwdata",bus.memwdata_o, v ? wd[g] : 32'h0);
            chk("rvalid0", bus.rvalid0_o, m_pend && !m_owner);
            chk("rvalid1", bus.rvalid1_o, m_pend && m_owner);
            chk("rdata0",  bus.rdata0_o, (m_pend && !m_owner) ? m_data : 32'h0);
            chk("rdata1",  bus.rdata1_o, (m_pend && m_owner)  ? m_data : 32'h0);
            if (v) $display("[TB] t=%0t port%0d %s addr=0x%02h data=0x%08h",
                            $time, g, we[g] ? "WR" : "RD", ad[g][7:0], we[g] ? wd[g] : model_mem[ad[g][7:0]]);
            m_pend = v && !we[g];
            if (v) begin
                m_last  = g;
                m_owner = g;
                if (we[g]) model_mem[ad[g][7:0]] = wd[g];
                else       m_data = model_mem[ad[g][7:0]];
            end
`ifdef MEM_ARB_LOCK_EN
            if (v && !forced && lk[g]) begin
                m_hold   = cont ? ((m_hold < MH) ? m_hold + 1 : m_hold) : 1;
                m_locked = 1'b1;
                m_lowner = g;
            end else begin
                m_locked = 1'b0;
                m_hold   = 0;
            end
`else
            if (forced || cont || lk[0]) m_pend = m_pend;
`endif
        end
    end

    task automatic step(); @(posedge clk); #1; endtask
    task automatic win();  @(negedge clk); #1; endtask

    task automatic set_port(input int p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.req0_i = r; bus.we0_i = w; bus.addr0_i = a; bus.wdata0_i = d;
        end else begin
            bus.req1_i = r; bus.we1_i = w; bus.addr1_i = a; bus.wdata1_i = d;
        end
    endtask

    initial begin : main
        bit [5:0] lock_exp;
        set_port(0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0);
`ifdef MEM_ARB_LOCK_EN
        bus.lock0_i = 1'b0; bus.lock1_i = 1'b0;
`endif
        // Contention right out of reset: port 0 first, then alternation
        set_port(0, 1, 0, 32'h10, 0);
        set_port(1, 1, 0, 32'h20, 0);
        repeat (3) step();
        rst = 1'b1;
        win(); chk("t1_gnt0_c1", bus.gnt0_o, 1); chk("t1_gnt1_c1", bus.gnt1_o, 0);
        win(); chk("t1_gnt1_c2", bus.gnt1_o, 1); chk("t1_rvalid0", bus.rvalid0_o, 1);
        chk("t1_rdata0", bus.rdata0_o, 32'h1000_0010);
        win(); chk("t1_gnt0_c3", bus.gnt0_o, 1); chk("t1_rvalid1", bus.rvalid1_o, 1);
        chk("t1_rdata1", bus.rdata1_o, 32'h1000_0020);

        // Port 1 writes alone, then port 0 reads it back
        step(); set_port(0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0);
        step(); set_port(1, 1, 1, 32'h40, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            win();
            chk("t2_gnt1", bus.gnt1_o, 1); chk("t2_memwrite", bus.memwrite_o, 1);
            chk("t2_memaddr", bus.memaddr_o, 32'h40); chk("t2_rvalid1", bus.rvalid1_o, 0);
        end
        step(); set_port(1, 0, 0, 0, 0); set_port(0, 1, 0, 32'h40, 0);
        win();  chk("t2_gnt0", bus.gnt0_o, 1);
        step(); set_port(0, 0, 0, 0, 0);
        win();  chk("t2_rvalid0", bus.rvalid0_o, 1); chk("t2_rdata0", bus.rdata0_o, 32'hDEADBEEF);

        // Read return overlapping a write issue
        step(); set_port(0, 1, 0, 32'h8, 0);
        win();  chk("t3_gnt0", bus.gnt0_o, 1);
        step(); set_port(0, 0, 0, 0, 0); set_port(1, 1, 1, 32'h44, 32'h1234_5678);
        win();  chk("t3_rvalid0", bus.rvalid0_o, 1); chk("t3_rdata0", bus.rdata0_o, 32'h1000_0008);
        chk("t3_memwrite", bus.memwrite_o, 1); chk("t3_rdata1", bus.rdata1_o, 0);

        // Reset right after a granted read
        step(); set_port(1, 0, 0, 0, 0); set_port(0, 1, 0, 32'h30, 0);
        win();  chk("t4_gnt0", bus.gnt0_o, 1);
        step(); rst = 1'b0; set_port(1, 1, 0, 32'h34, 0);
        #1;
        chk("t4_gnt", {bus.gnt1_o, bus.gnt0_o}, 0); chk("t4_rvalid0", bus.rvalid0_o, 0);
        chk("t4_memread", bus.memread_o, 0); chk("t4_memaddr", bus.memaddr_o, 0);
        step(); step(); rst = 1'b1;
        win();  chk("t4_post_rvalid0", bus.rvalid0_o, 0); chk("t4_post_gnt0", bus.gnt0_o, 1);

        // Lock: port 0 holds for MH grants, then yields; plain alternation otherwise
        step(); rst = 1'b0;
        set_port(0, 1, 0, 32'h50, 0); set_port(1, 1, 0, 32'h60, 0);
`ifdef MEM_ARB_LOCK_EN
        bus.lock0_i = 1'b1;
        lock_exp = 6'b101111;
`else
        lock_exp = 6'b010101;
`endif
        step(); rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            win(); chk($sformatf("t5_gnt0_c%0d", i + 1), bus.gnt0_o, lock_exp[i]);
        end
        step(); set_port(0, 0, 0, 0, 0); set_port(1, 0, 0, 0, 0);
`ifdef MEM_ARB_LOCK_EN
        bus.lock0_i = 1'b0;
`endif

        // Idle bus
        win();
        for (int i = 0; i < 10; i++) begin
            win();
            chk("t6_gnt", {bus.gnt1_o, bus.gnt0_o}, 0);
            chk("t6_mem", {bus.memread_o, bus.memwrite_o}, 0);
            chk("t6_memaddr", bus.memaddr_o, 0);
            chk("t6_rvalid", {bus.rvalid1_o, bus.rvalid0_o}, 0);
        end

        // Random traffic; a waiting requester keeps its request stable
        for (int c = 0; c < 400; c++) begin
            bit keep0, keep1;
            step();
            keep0 = rst && bus.req0_i && !bus.gnt0_o;
            keep1 = rst && bus.req1_i && !bus.gnt1_o;
            if (!keep0) set_port(0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                                 32'($urandom_range(0, 255)), $urandom);
            if (!keep1) set_port(1, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                                 32'($urandom_range(0, 255)), $urandom);
`ifdef MEM_ARB_LOCK_EN
            bus.lock0_i = ($urandom_range(0, 3) != 0);
            bus.lock1_i = ($urandom_range(0, 3) != 0);
`endif
            rst = ($urandom_range(0, 59) != 0);
        end
        step(); rst = 1'b1;
        win();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
